tdc_core: RTL and testbench

TDC_CORE -- requirements
Module: tdc_core

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tdc_delay_line.sv | 57 +++++
 rtl/tdc_core.sv | 102 ++++++++++
 tb/tb_tdc_core.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and FSM encoding for the tapped-delay-line TDC.
// No logic here; imported by tdc_delay_line and tdc_core.
`timescale 1ns/1ps
package tdc_pkg;

    localparam int NTAPS = 31;
    localparam int BIN_W = 5;
    localparam int CNT_W = 48;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

endpackage

// File: rtl/tdc_delay_line.sv
// Delay-line taps, thermometer capture registers and popcount fine-code encoders.
// Latency: codes valid the edge after a capture strobe; no backpressure, strobes always honoured.
`timescale 1ns/1ps
module tdc_delay_line
    import tdc_pkg::*;
#(
    parameter int  NTAPS     = tdc_pkg::NTAPS,
    parameter real TAP_DELAY = 0.3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hit,
    input  logic             i_cap_start,
    input  logic             i_cap_stop,
    output logic [BIN_W-1:0] o_bin_start,
    output logic [BIN_W-1:0] o_bin_stop
);

    logic [NTAPS-1:0] w_tap;
    logic [NTAPS-1:0] r_therm_start;
    logic [NTAPS-1:0] r_therm_stop;
    logic [BIN_W-1:0] w_pop_start;
    logic [BIN_W-1:0] w_pop_stop;

    // Behavioural tap delays; a silicon build maps these onto a placed carry chain.
    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
`ifdef SYNTHESIS
        assign w_tap[i] = i_hit;
`else
        assign #((i + 1) * TAP_DELAY) w_tap[i] = i_hit;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_therm_start <= '0;
            r_therm_stop  <= '0;
        end else begin
            if (i_cap_start) r_therm_start <= w_tap;
            if (i_cap_stop)  r_therm_stop  <= ~w_tap;
        end
    end

    // Counting ones rather than finding the 1->0 transition tolerates bubbles.
    always_comb begin
        w_pop_start = '0;
        w_pop_stop  = '0;
        for (int i = 0; i < NTAPS; i++) begin
            w_pop_start = w_pop_start + BIN_W'(r_therm_start[i]);
            w_pop_stop  = w_pop_stop  + BIN_W'(r_therm_stop[i]);
        end
    end

    assign o_bin_start = w_pop_start;
    assign o_bin_stop  = w_pop_stop;

endmodule

// File: rtl/tdc_core.sv
// Pulse-width TDC: fine START/STOP codes from the delay line plus a 48-bit coarse edge count.
// Outputs update on the capture edge itself; no backpressure. Optional done pulse with TDC_DONE_EN.
`timescale 1ns/1ps
module tdc_core
    import tdc_pkg::*;
#(
    parameter int  NTAPS     = tdc_pkg::NTAPS,
    parameter real TAP_DELAY = 0.3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit,
    output logic [BIN_W-1:0] bin_out_start,
    output logic [BIN_W-1:0] bin_out_stop,
    output logic [CNT_W-1:0] out_count
`ifdef TDC_DONE_EN
    ,
    output logic             done
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_h0_prev;
    logic             w_h0;
    logic             w_cap_start;
    logic             w_cap_stop;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_out_count;

    assign w_h0 = hit;

    tdc_delay_line #(
        .NTAPS     (NTAPS),
        .TAP_DELAY (TAP_DELAY)
    ) u_delay_line (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_hit       (w_h0),
        .i_cap_start (w_cap_start),
        .i_cap_stop  (w_cap_stop),
        .o_bin_start (bin_out_start),
        .o_bin_stop  (bin_out_stop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap_start = 1'b0;
        w_cap_stop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_h0 && !r_h0_prev) begin
                    w_cap_start = 1'b1;
                    w_state_nxt = MEAS;
                end
            end
            MEAS: begin
                if (!w_h0) begin
                    w_cap_stop  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Previous-h0 resets high so a hit already asserted at reset release is not a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h0_prev   <= 1'b1;
            r_cnt       <= '0;
            r_out_count <= '0;
        end else begin
            r_h0_prev <= w_h0;
            if (w_cap_start)
                r_cnt <= CNT_W'(1);
            else if (r_state == MEAS && w_h0)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_cap_stop)
                r_out_count <= r_cnt;
        end
    end

    assign out_count = r_out_count;

`ifdef TDC_DONE_EN
    logic r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= w_cap_stop;
    end

    assign done = r_done;
`endif

endmodule

// File: tb/tb_tdc_core.sv
// Directed bench for tdc_core: expected output triples are queued when hit/rst_n are driven
// and popped/compared just after the edge at which the DUT is due to respond.
`timescale 1ns/1ps
module tb_tdc_core;

    typedef struct {
        string       tag;
        logic [4:0]  start;
        logic [4:0]  stop;
        logic [47:0] count;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        hit;
    logic [4:0]  bin_out_start;
    logic [4:0]  bin_out_stop;
    logic [47:0] out_count;
`ifdef TDC_DONE_EN
    logic        done;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // ClockGen: low at t=0, first rising edge at 5 ns, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    tdc_core #(
        .NTAPS     (31),
        .TAP_DELAY (0.3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hit           (hit),
        .bin_out_start (bin_out_start),
        .bin_out_stop  (bin_out_stop),
`ifdef TDC_DONE_EN
        .done          (done),
`endif
        .out_count     (out_count)
    );

    task automatic at(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic push(input string tag, input logic [4:0] s, input logic [4:0] p,
                        input logic [47:0] c);
        exp_t e;
        e.tag   = tag;
        e.start = s;
        e.stop  = p;
        e.count = c;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_errors++;
            $error("FAIL scoreboard_underflow: got %0d entries, expected at least 1", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            assert (bin_out_start === e.start) else begin
                n_errors++;
                $error("FAIL %s.bin_out_start: got %0d expected %0d", e.tag, bin_out_start, e.start);
            end
            n_checks++;
            assert (bin_out_stop === e.stop) else begin
                n_errors++;
                $error("FAIL %s.bin_out_stop: got %0d expected %0d", e.tag, bin_out_stop, e.stop);
            end
            n_checks++;
            assert (out_count === e.count) else begin
                n_errors++;
                $error("FAIL %s.out_count: got %0d expected %0d", e.tag, out_count, e.count);
            end
        end
    endtask

`ifdef TDC_DONE_EN
    task automatic check_done(input string tag, input logic exp);
        n_checks++;
        assert (done === exp) else begin
            n_errors++;
            $error("FAIL %s: got %b expected %b", tag, done, exp);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        hit   = 1'b0;
        #0.5 rst_n = 1'b0;

        at(2.0);    push("reset", 5'd0, 5'd0, 48'd0);            check_out();
        at(12.0);   rst_n = 1'b1;
        at(26.0);   push("idle_after_reset", 5'd0, 5'd0, 48'd0); check_out();

        // Rise 4.0 ns before the 125 ns edge -> 13 taps; fall 4.0 ns before 285 ns.
        at(121.0);  hit = 1'b1;
        push("before_capture_edge", 5'd0, 5'd0, 48'd0);
        at(124.0);  check_out();
        push("start_13", 5'd13, 5'd0, 48'd0);
        at(126.0);  check_out();
`ifdef TDC_DONE_EN
        at(276.0);  check_done("done_low_before_stop", 1'b0);
`endif
        at(281.0);  hit = 1'b0;
        push("stop_13", 5'd13, 5'd13, 48'd16);
        at(286.0);  check_out();
`ifdef TDC_DONE_EN
        check_done("done_high_after_stop", 1'b1);
        at(296.0);  check_done("done_one_cycle", 1'b0);
`endif

        // Fall placed 9.05 ns before 765 ns so tap 30 (9.0 ns) lands clear of the edge.
        at(513.0);  hit = 1'b1;
        push("start_6", 5'd6, 5'd13, 48'd16);
        at(516.0);  check_out();
        at(755.95); hit = 1'b0;
        push("stop_30", 5'd6, 5'd30, 48'd25);
        at(766.0);  check_out();

        // Pulse wholly between the 815 and 825 ns edges is invisible.
        at(822.0);  hit = 1'b1;
        at(824.0);  hit = 1'b0;
        push("no_edge_pulse", 5'd6, 5'd30, 48'd25);
        at(836.0);  check_out();

        // A low glitch inside MEAS that no edge samples must not restart the measurement.
        at(901.0);  hit = 1'b1;
        push("start_b", 5'd13, 5'd30, 48'd25);
        at(906.0);  check_out();
        at(912.0);  hit = 1'b0;
        at(913.0);  hit = 1'b1;
        push("meas_rise_ignored", 5'd13, 5'd30, 48'd25);
        at(926.0);  check_out();
        at(951.0);  hit = 1'b0;
        push("stop_b", 5'd13, 5'd13, 48'd5);
        at(956.0);  check_out();

        // Elapsed 9.5 ns and 9.4 ns both exceed 31 taps -> saturated codes.
        at(1005.5); hit = 1'b1;
        push("start_saturated", 5'd31, 5'd13, 48'd5);
        at(1016.0); check_out();
        at(1095.6); hit = 1'b0;
        push("stop_saturated", 5'd31, 5'd31, 48'd9);
        at(1106.0); check_out();

        // Reset mid-measurement aborts; hit still high at release must not START.
        at(1121.0); hit = 1'b1;
        push("start_c", 5'd13, 5'd31, 48'd9);
        at(1126.0); check_out();
        at(1200.0); rst_n = 1'b0;
        push("reset_abort", 5'd0, 5'd0, 48'd0);
        at(1201.0); check_out();
        at(1212.0); rst_n = 1'b1;
        push("hit_high_at_release", 5'd0, 5'd0, 48'd0);
        at(1226.0); check_out();
        at(1281.0); hit = 1'b0;
        push("no_stop_after_abort", 5'd0, 5'd0, 48'd0);
        at(1296.0); check_out();

        at(1321.0); hit = 1'b1;
        push("start_d", 5'd13, 5'd0, 48'd0);
        at(1326.0); check_out();
        at(1401.0); hit = 1'b0;
        push("stop_d", 5'd13, 5'd13, 48'd8);
        at(1406.0); check_out();

        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
